// File: rtl/gen_cubo_pkg.sv
// Shared definitions for the falling-cube spawner: FSM states, frame-tick position,
// LFSR taps, level ceiling and the launch-x folding helper.
package gen_cubo_pkg;

  typedef enum logic [1:0] {
    E_IDLE     = 2'd0,
    E_ESPERA   = 2'd1,
    E_LANZAR   = 2'd2,
    E_EN_VUELO = 2'd3
  } estado_e;

  localparam logic [9:0] FRAME_Y = 10'd481;
  localparam logic [9:0] FRAME_X = 10'd0;

  // x^9 + x^5 + 1 as a left-shifting Fibonacci register: feedback from bits 8 and 4
  localparam int LFSR_TAP_A = 8;
  localparam int LFSR_TAP_B = 4;

  localparam logic [1:0] NIVEL_MAX = 2'd2;

  // Folds the 9-bit random value into 0..x_max; values above x_max wrap to the bottom
  function automatic logic [8:0] mapear_x(input logic [8:0] v, input logic [8:0] x_max);
    logic [8:0] r;
    if (v <= x_max) r = v;
    else            r = v - x_max - 9'd1;
    return r;
  endfunction

  function automatic logic [1:0] subir_nivel(input logic [1:0] n);
    logic [1:0] r;
    if (n >= NIVEL_MAX) r = NIVEL_MAX;
    else                r = n + 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/generador_cubo_lfsr9.sv
// Free-running 9-bit maximal-length LFSR; a zero seed is replaced by 9'h001 so the
// register can never lock up at zero.
module lfsr9
  import gen_cubo_pkg::*;
#(
  parameter logic [8:0] SEED = 9'h1A5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [8:0] q
);

  localparam logic [8:0] SEED_OK = (SEED == 9'd0) ? 9'h001 : SEED;

  logic [8:0] lfsr_q;
  logic [8:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[7:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= SEED_OK;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/generador_cubo.sv
// Cube spawner: waits FRAMES_ESPERA frames, launches a cube at a pseudo-random x with a
// level-dependent speed, and raises the level every CUBOS_POR_NIVEL completed cubes.
// Optional build macro GENERADOR_PAUSA_EN adds a 'pausa' input that freezes the wait.
module generador_cubo
  import gen_cubo_pkg::*;
#(
  parameter int         FRAMES_ESPERA   = 30,
  parameter int         X_MAX           = 448,
  parameter logic [8:0] LFSR_SEED       = 9'h1A5,
  parameter int         CUBOS_POR_NIVEL = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       juego_activo,
  input  logic       terminado_cubo,
`ifdef GENERADOR_PAUSA_EN
  input  logic       pausa,
`endif
  output logic       start,
  output logic [8:0] posicion_x_inicial_aleatoria,
  output logic [1:0] velocidad_cubo,
  output logic [1:0] nivel,
  output logic [7:0] cubos_lanzados
);

  localparam int FC_W = (FRAMES_ESPERA > 1) ? $clog2(FRAMES_ESPERA) : 1;
  localparam int DC_W = (CUBOS_POR_NIVEL > 1) ? $clog2(CUBOS_POR_NIVEL) : 1;
  localparam logic [FC_W-1:0] FRAMES_ULT = FC_W'(FRAMES_ESPERA - 1);
  localparam logic [DC_W-1:0] HECHOS_ULT = DC_W'(CUBOS_POR_NIVEL - 1);
  localparam logic [8:0]      X_MAX9     = 9'(X_MAX);

  logic pausa_act;
`ifdef GENERADOR_PAUSA_EN
  assign pausa_act = pausa;
`else
  assign pausa_act = 1'b0;
`endif

  logic [8:0] lfsr;

  lfsr9 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  // Frame tick: first clock of the scan sitting at the frame position
  logic raw;
  logic raw_q;
  logic tick;

  assign raw  = (pixel_y == FRAME_Y) && (pixel_x == FRAME_X);
  assign tick = raw & ~raw_q;

  estado_e           estado_q,   estado_d;
  logic [FC_W-1:0]   frames_q,   frames_d;
  logic [DC_W-1:0]   hechos_q,   hechos_d;
  logic [1:0]        nivel_q,    nivel_d;
  logic              start_q,    start_d;
  logic [8:0]        x_q,        x_d;
  logic [1:0]        vel_q,      vel_d;
  logic [7:0]        lanzados_q, lanzados_d;

  always_comb begin
    estado_d   = estado_q;
    frames_d   = frames_q;
    hechos_d   = hechos_q;
    nivel_d    = nivel_q;
    start_d    = 1'b0;
    x_d        = x_q;
    vel_d      = vel_q;
    lanzados_d = lanzados_q;

    if (!juego_activo) begin
      estado_d = E_IDLE;
    end else begin
      case (estado_q)
        E_IDLE: begin
          estado_d = E_ESPERA;
          frames_d = '0;
        end
        E_ESPERA: begin
          if (tick && !pausa_act) begin
            if (frames_q == FRAMES_ULT) estado_d = E_LANZAR;
            else                        frames_d = frames_q + 1'b1;
          end
        end
        E_LANZAR: begin
          // Speed is latched here only, so a level change never touches a cube in flight
          start_d    = 1'b1;
          x_d        = mapear_x(lfsr, X_MAX9);
          vel_d      = nivel_q + 2'd1;
          lanzados_d = lanzados_q + 8'd1;
          estado_d   = E_EN_VUELO;
        end
        E_EN_VUELO: begin
          if (terminado_cubo) begin
            estado_d = E_ESPERA;
            frames_d = '0;
            if (hechos_q == HECHOS_ULT) begin
              hechos_d = '0;
              nivel_d  = subir_nivel(nivel_q);
            end else begin
              hechos_d = hechos_q + 1'b1;
            end
          end
        end
        default: estado_d = E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_q      <= 1'b0;
      estado_q   <= E_IDLE;
      frames_q   <= '0;
      hechos_q   <= '0;
      nivel_q    <= 2'd0;
      start_q    <= 1'b0;
      x_q        <= 9'd0;
      vel_q      <= 2'd1;
      lanzados_q <= 8'd0;
    end else begin
      raw_q      <= raw;
      estado_q   <= estado_d;
      frames_q   <= frames_d;
      hechos_q   <= hechos_d;
      nivel_q    <= nivel_d;
      start_q    <= start_d;
      x_q        <= x_d;
      vel_q      <= vel_d;
      lanzados_q <= lanzados_d;
    end
  end

  assign start                        = start_q;
  assign posicion_x_inicial_aleatoria = x_q;
  assign velocidad_cubo               = vel_q;
  assign nivel                        = nivel_q;
  assign cubos_lanzados               = lanzados_q;

endmodule

// File: tb/tb_generador_cubo.sv
// Randomized bench for generador_cubo: frames with random hold lengths, ignored
// completions, an abandoned cube, mid-wait async reset, checked against a behavioural model.
module tb_generador_cubo;

  localparam int         FW   = 3;
  localparam int         XM   = 448;
  localparam int         CPN  = 8;
  localparam logic [8:0] SEED = 9'h1A5;
  localparam int         NCUB = 27;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pixel_x = 10'd5;
  logic [9:0] pixel_y = 10'd0;
  logic       juego_activo = 1'b0;
  logic       terminado_cubo = 1'b0;
`ifdef GENERADOR_PAUSA_EN
  logic       pausa = 1'b0;
`endif
  logic       start;
  logic [8:0] pos_x;
  logic [1:0] vel;
  logic [1:0] nivel;
  logic [7:0] lanzados;

  generador_cubo #(
    .FRAMES_ESPERA   (FW),
    .X_MAX           (XM),
    .LFSR_SEED       (SEED),
    .CUBOS_POR_NIVEL (CPN)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .pixel_x                      (pixel_x),
    .pixel_y                      (pixel_y),
    .juego_activo                 (juego_activo),
    .terminado_cubo               (terminado_cubo),
`ifdef GENERADOR_PAUSA_EN
    .pausa                        (pausa),
`endif
    .start                        (start),
    .posicion_x_inicial_aleatoria (pos_x),
    .velocidad_cubo               (vel),
    .nivel                        (nivel),
    .cubos_lanzados               (lanzados)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [8:0] lfsr_m = SEED;
  logic [8:0] lfsr_prev = SEED;
  int done_total = 0;
  int launches_m = 0;
  int n_start = 0;
  bit start_prev = 1'b0;

  function automatic logic [8:0] lfsr_paso(input logic [8:0] v);
    return {v[7:0], v[8] ^ v[4]};
  endfunction

  function automatic int x_esperada(input logic [8:0] v);
    int r;
    r = (int'(v) <= XM) ? int'(v) : int'(v) - XM - 1;
    return r;
  endfunction

  function automatic int nivel_esp(input int hechos);
    return (hechos / CPN > 2) ? 2 : hechos / CPN;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      lfsr_prev = lfsr_m;
      lfsr_m    = lfsr_paso(lfsr_m);
    end
  end

  // Launch monitor: width, position, speed and launch counter of every start pulse
  always @(negedge clk) begin
    if (!reset) begin
      start_prev = 1'b0;
    end else begin
      if (start) begin
        check_eq("start_width", 32'(start_prev), 0);
        n_start++;
        launches_m++;
        check_eq("launch_x", 32'(pos_x), x_esperada(lfsr_prev));
        check_eq("launch_vel", 32'(vel), nivel_esp(done_total) + 1);
        check_eq("launch_count", 32'(lanzados), launches_m % 256);
      end
      start_prev = start;
    end
  end

  task automatic frame(input int hold, input int gap);
    @(negedge clk);
    pixel_y = 10'd481;
    pixel_x = 10'd0;
    repeat (hold) @(negedge clk);
    if ($urandom_range(0, 1) == 1) begin
      pixel_x = 10'($urandom_range(1, 799));
    end else begin
      pixel_y = 10'($urandom_range(0, 480));
      pixel_x = 10'd0;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulso_terminado();
    @(negedge clk);
    terminado_cubo = 1'b1;
    @(negedge clk);
    terminado_cubo = 1'b0;
  endtask

  // Full wait phase: no launch before the last frame, exactly one right after it
  task automatic espera_y_lanza(input string tag);
    int base;
    base = n_start;
    for (int f = 1; f <= FW; f++) begin
      frame($urandom_range(1, 4), $urandom_range(3, 6));
      if (f < FW) check_eq({tag, "_no_early_start"}, 32'(n_start), 32'(base));
    end
    check_eq({tag, "_one_start"}, 32'(n_start), 32'(base + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    juego_activo = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_x", 32'(pos_x), 0);
    check_eq("rst_vel", 32'(vel), 1);
    check_eq("rst_nivel", 32'(nivel), 0);
    check_eq("rst_lanzados", 32'(lanzados), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NCUB; i++) begin
      if ($urandom_range(0, 1) == 1) pulso_terminado();
      espera_y_lanza("wait");
      repeat ($urandom_range(0, 2)) frame($urandom_range(1, 4), 3);
      if (i == 7) begin
        // Abandon the cube: completion while inactive must not count
        base = n_start;
        @(negedge clk);
        juego_activo = 1'b0;
        pulso_terminado();
        repeat (FW) frame(1, 3);
        check_eq("abort_nivel", 32'(nivel), nivel_esp(done_total));
        check_eq("abort_no_start", 32'(n_start), 32'(base));
        @(negedge clk);
        juego_activo = 1'b1;
        repeat (2) @(negedge clk);
      end else begin
        pulso_terminado();
        done_total++;
        @(negedge clk);
        check_eq("nivel", 32'(nivel), nivel_esp(done_total));
      end
    end
    check_eq("total_lanzados", 32'(lanzados), 32'(NCUB));

    // Async reset while waiting
    frame(2, 3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    lfsr_m = SEED;
    lfsr_prev = SEED;
    done_total = 0;
    launches_m = 0;
    #1;
    check_eq("arst_start", 32'(start), 0);
    check_eq("arst_x", 32'(pos_x), 0);
    check_eq("arst_vel", 32'(vel), 1);
    check_eq("arst_nivel", 32'(nivel), 0);
    check_eq("arst_lanzados", 32'(lanzados), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    espera_y_lanza("post_rst");
    check_eq("post_rst_lanzados", 32'(lanzados), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
